// File: rtl/dds_wave_capture_pkg.sv
// Shared types and defaults for the DDS wave capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dds_wave_capture_pkg;

  localparam int DFLT_DATA_W  = 8;
  localparam int DFLT_ADDR_W  = 10;
  localparam int DFLT_DECIM_W = 16;

  // Trigger slope encodings as presented on trig_slope_i
  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/wave_cap_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port, read-first.
// Latency: rd_data_o valid one cycle after rd_addr_i; write lands at the clock edge.
// Backpressure: none; both ports accept an access every cycle.
module wave_cap_ram
  import dds_wave_capture_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Array write; storage contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read sees the array before this cycle's write lands (read-first).
  always_comb begin
    rd_data_d = mem_q[rd_addr_i];
  end

  // Registered read port, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dds_wave_capture.sv
// Triggered, decimated single-frame capture of the DDS sample stream (optional auto-trigger: DDS_WAVE_CAPTURE_AUTO_TRIG_EN).
// Latency: trigger sample written the cycle it arrives; done_o rises one cycle after the last write; reads take one cycle.
// Backpressure: none; wave_valid_i only qualifies samples, invalid cycles are ignored.
module dds_wave_capture
  import dds_wave_capture_pkg::*;
#(
  parameter int DATA_W  = DFLT_DATA_W,
  parameter int ADDR_W  = DFLT_ADDR_W,
  parameter int DECIM_W = DFLT_DECIM_W
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 1_000_000
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  wave_i,
  input  logic               wave_valid_i,
  input  logic               arm_i,
  input  logic [DATA_W-1:0]  trig_level_i,
  input  logic               trig_slope_i,
  input  logic [DECIM_W-1:0] decim_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               auto_trig_o,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0]  rd_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  cap_state_e               state_q, state_d;
  logic signed [DATA_W-1:0] level_q, level_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     slope_q, slope_d;
  logic                     prev_vld_q, prev_vld_d;
  logic [DECIM_W-1:0]       decim_q, decim_d;
  logic [DECIM_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]        ram_waddr;
  logic                     ram_we;
  logic                     crossing;
  logic                     fire;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     auto_q, auto_d;
`endif

  // Signed level-crossing between the previous and the current sample.
  always_comb begin
    if (slope_q == SLOPE_FALL) crossing = (prev_q > level_q) && ($signed(wave_i) <= level_q);
    else                       crossing = (prev_q < level_q) && ($signed(wave_i) >= level_q);
  end

  // Next-state, trigger, decimation and write-address control; arm overrides everything.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    slope_d    = slope_q;
    decim_d    = decim_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr_q;
    fire       = 1'b0;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
    tmo_d      = tmo_q;
    auto_d     = auto_q;
`endif
    case (state_q)
      ST_WAIT_TRIG: begin
        if (wave_valid_i) begin
          prev_d     = wave_i;
          prev_vld_d = 1'b1;
          fire       = prev_vld_q && crossing;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
          tmo_d = tmo_q + 1'b1;
          if (!fire && (tmo_q == TMO_W'(AUTO_TIMEOUT - 1))) begin
            fire   = 1'b1;
            auto_d = 1'b1;
          end
`endif
          if (fire) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            wr_addr_d = {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_d     = decim_q;
            state_d   = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (wave_valid_i) begin
          if (cnt_q == '0) begin
            ram_we = 1'b1;
            cnt_d  = decim_q;
            if (wr_addr_q == LAST_ADDR) state_d = ST_DONE;
            else                        wr_addr_d = wr_addr_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (arm_i) begin
      state_d    = ST_WAIT_TRIG;
      level_d    = trig_level_i;
      slope_d    = trig_slope_i;
      decim_d    = decim_i;
      prev_vld_d = 1'b0;
      cnt_d      = '0;
      wr_addr_d  = '0;
      ram_we     = 1'b0;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
      tmo_d      = '0;
      auto_d     = 1'b0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      slope_q    <= SLOPE_RISE;
      decim_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
      tmo_q      <= '0;
      auto_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      slope_q    <= slope_d;
      decim_q    <= decim_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
      tmo_q      <= tmo_d;
      auto_q     <= auto_d;
`endif
    end
  end

  assign busy_o = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
  assign done_o = (state_q == ST_DONE);
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
  assign auto_trig_o = auto_q;
`else
  assign auto_trig_o = 1'b0;
`endif

  wave_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (wave_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_dds_wave_capture.sv
// Bench for dds_wave_capture: frame model indexed by valid-sample position, per-cycle compare, literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_dds_wave_capture;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
  localparam int TMO   = 16;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic signed [DW-1:0] wave_i = '0;
  logic                 wave_valid_i = 1'b0;
  logic                 arm_i = 1'b0;
  logic signed [DW-1:0] trig_level_i = '0;
  logic                 trig_slope_i = 1'b0;
  logic [15:0]          decim_i = '0;
  logic                 busy_o, done_o, auto_trig_o;
  logic [AW-1:0]        rd_addr_i = '0;
  logic signed [DW-1:0] rd_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
  dds_wave_capture #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(16), .AUTO_TIMEOUT(TMO)) dut (
`else
  dds_wave_capture #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(16)) dut (
`endif
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wave_i       (wave_i),
    .wave_valid_i (wave_valid_i),
    .arm_i        (arm_i),
    .trig_level_i (trig_level_i),
    .trig_slope_i (trig_slope_i),
    .decim_i      (decim_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .auto_trig_o  (auto_trig_o),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o)
  );

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame slot k holds the valid sample at position trig + k*(decim+1) counted from the
  // trigger sample; the frame is complete once slot DEPTH-1 has been filled.
  logic signed [DW-1:0] exp_mem [DEPTH];
  bit                   exp_known [DEPTH];
  logic signed [DW-1:0] vs [$];
  bit                   m_armed = 0, m_done = 0, m_auto = 0, m_fall = 0;
  int                   trig_idx = -1, m_step = 1, mn, mpos;
  logic signed [DW-1:0] m_lvl = '0;
  logic signed [DW-1:0] exp_rd = '0;
  bit                   exp_rd_ok = 0;
  bit                   rd_chk = 0;

  function automatic bit crosses(input bit fall, input logic signed [DW-1:0] lvl,
                                 input logic signed [DW-1:0] p, input logic signed [DW-1:0] s);
    return fall ? (p > lvl && s <= lvl) : (p < lvl && s >= lvl);
  endfunction

  always @(posedge clk_i) begin
    exp_rd    = exp_mem[rd_addr_i];
    exp_rd_ok = rd_chk && exp_known[rd_addr_i];
    if (rst_i) begin
      m_armed = 0; m_done = 0; m_auto = 0; trig_idx = -1; vs.delete();
      exp_rd = '0; exp_rd_ok = 1;
    end else if (arm_i) begin
      m_armed = 1; m_done = 0; m_auto = 0; trig_idx = -1; vs.delete();
      m_lvl = trig_level_i; m_fall = trig_slope_i; m_step = int'(decim_i) + 1;
    end else if (m_armed && !m_done && wave_valid_i) begin
      vs.push_back(wave_i);
      mn = vs.size();
      if (trig_idx < 0 && mn >= 2 && crosses(m_fall, m_lvl, vs[mn-2], vs[mn-1])) trig_idx = mn - 1;
`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
      if (trig_idx < 0 && mn == TMO) begin trig_idx = mn - 1; m_auto = 1; end
`endif
      if (trig_idx >= 0) begin
        mpos = mn - 1 - trig_idx;
        if (mpos % m_step == 0) begin
          exp_mem[mpos / m_step]   = wave_i;
          exp_known[mpos / m_step] = 1;
          if (mpos / m_step == DEPTH - 1) m_done = 1;
        end
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk_i) begin
    chk("busy", busy_o, m_armed && !m_done);
    chk("done", done_o, m_done);
    chk("auto_trig", auto_trig_o, m_auto);
    if (exp_rd_ok) chk("rd_data", rd_data_o, exp_rd);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_arm(input int lvl, input bit fall, input int dec);
    trig_level_i = 8'(lvl); trig_slope_i = fall; decim_i = 16'(dec);
    arm_i = 1'b1; wave_valid_i = 1'b0;
    step();
    arm_i = 1'b0;
  endtask

  task automatic feed(input logic signed [DW-1:0] w);
    wave_i = w; wave_valid_i = 1'b1;
    step();
    wave_valid_i = 1'b0;
  endtask

  // Ramp from start by dir per valid sample until done_o or cycle limit; returns valid count.
  task automatic run_ramp(input int start, input int dir, input bit toggle, input int limit, output int nvalid);
    logic signed [DW-1:0] w;
    w = 8'(start);
    nvalid = 0;
    for (int c = 0; c < limit && !done_o; c++) begin
      if (toggle && c[0]) begin
        wave_i = 8'($urandom); wave_valid_i = 1'b0;
        step();
      end else begin
        feed(w);
        w = w + 8'(dir);
        nvalid++;
      end
    end
  endtask

  task automatic readback();
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr_i = AW'(k); rd_chk = 1;
      step();
    end
    rd_chk = 0;
  endtask

  task automatic rd_lit(input int a, input int req, input string nm);
    rd_addr_i = AW'(a);
    step();
    chk(nm, rd_data_o, req);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    @(negedge clk_i);
    step(); step();
    rst_i = 1'b0;
    step();

    // 1: reset in the middle of a capture
    do_arm(0, 0, 0);
    run_ramp(-3, 1, 0, 50, nv);
    chk("t1_busy_mid", busy_o, 1);
    rst_i = 1'b1;
    step(); step(); step();
    chk("t1_busy_rst", busy_o, 0);
    chk("t1_done_rst", done_o, 0);
    chk("t1_auto_rst", auto_trig_o, 0);
    chk("t1_rd_rst", rd_data_o, 0);
    rst_i = 1'b0;
    run_ramp(-3, 1, 0, 10, nv);
    chk("t1_idle_no_arm", busy_o, 0);

    // 2: rising ramp, level 0, no decimation
    do_arm(0, 0, 0);
    run_ramp(-3, 1, 0, 2000, nv);
    chk("t2_len", nv - 3, 1024);
    chk("t2_done", done_o, 1);
    chk("t2_busy", busy_o, 0);
    readback();
    rd_lit(5, 5, "t2_mem5");
    rd_lit(128, -128, "t2_mem128");
    rd_lit(1023, -1, "t2_mem1023");

    // 3: decimation by 4
    do_arm(0, 0, 3);
    chk("t3_done_clr", done_o, 0);
    run_ramp(-3, 1, 0, 5000, nv);
    chk("t3_len", nv - 3, 4093);
    readback();
    rd_lit(0, 0, "t3_mem0");
    rd_lit(1, 4, "t3_mem1");
    rd_lit(32, -128, "t3_mem32");
    rd_lit(100, -112, "t3_mem100");

    // 4: falling slope at 50; a rising jump through 50 precedes it
    do_arm(50, 1, 0);
    feed(49);
    feed(60);
    run_ramp(55, -1, 0, 2000, nv);
    chk("t4_len", nv, 6 + 1023);
    readback();
    rd_lit(0, 50, "t4_mem0");
    rd_lit(1, 49, "t4_mem1");
    rd_lit(200, 106, "t4_mem200");

    // 5: ramp with gaps and garbage on invalid cycles
    do_arm(0, 0, 0);
    run_ramp(-3, 1, 1, 3000, nv);
    chk("t5_len", nv - 3, 1024);
    readback();
    rd_lit(5, 5, "t5_mem5");
    rd_lit(1023, -1, "t5_mem1023");

    // 6: re-arm with wr_addr at 500, new level 10
    do_arm(0, 0, 0);
    run_ramp(-3, 1, 0, 503, nv);
    chk("t6_busy_500", busy_o, 1);
    do_arm(10, 0, 0);
    chk("t6_busy_rearm", busy_o, 1);
    chk("t6_done_rearm", done_o, 0);
    run_ramp(5, 1, 0, 2000, nv);
    chk("t6_len", nv - 5, 1024);
    readback();
    rd_lit(0, 10, "t6_mem0");
    rd_lit(1, 11, "t6_mem1");
    rd_lit(500, -2, "t6_mem500");

`ifdef DDS_WAVE_CAPTURE_AUTO_TRIG_EN
    // 6b: forced trigger on the 16th valid sample of a flat wave
    do_arm(100, 0, 0);
    for (int i = 0; i < TMO - 1; i++) feed(0);
    chk("t6b_auto_before", auto_trig_o, 0);
    feed(0);
    chk("t6b_auto_after", auto_trig_o, 1);
    chk("t6b_busy", busy_o, 1);
    rd_lit(0, 0, "t6b_mem0");
    do_arm(100, 0, 0);
    chk("t6b_auto_clr", auto_trig_o, 0);
`else
    chk("t6_auto_tied", auto_trig_o, 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
